cardinal_nic: RTL and testbench
===============================

# cardinal_nic

Network interface controller between one Cardinal CPU's NIC port and its local router port in the 4-node CMP. It holds one 64-bit packet slot per direction (CPU→network output channel, network→CPU input channel) and exposes both slots plus status words as four memory-mapped registers on the CPU's MEM-stage NIC bus. Router-side transfers use a ready/send handshake gated by the router's virtual-channel polarity.

## Interface
Parameters:
- DATA_WIDTH, 64, packet/register width; bits numbered [0:DATA_WIDTH-1], bit 0 is MSB.
- VC_BIT, 0, packet bit holding the virtual-channel tag.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- addr_nic  in  [0:1]  register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
- din_nic  in  [0:63]  CPU write data.
- dout_nic  out  [0:63]  CPU read data.
- nicEn  in  1  access enable.
- nicWrEn  in  1  write when 1, read when 0; qualified by nicEn.
- net_si  in  1  router has a packet for this NIC.
- net_ri  out  1  NIC can accept a packet.
- net_di  in  [0:63]  packet from router.
- net_so  out  1  NIC offers a packet.
- net_ro  in  1  router can accept a packet.
- net_do  out  [0:63]  packet to router.
- net_polarity  in  1  router's current external VC phase.

## Operation
- State: ibuf[0:63] + ibuf_full; obuf[0:63] + obuf_full.
- CPU read (nicEn=1, nicWrEn=0), combinational dout_nic:
  - 00: ibuf; ibuf_full cleared at next edge. Reading while empty returns stale ibuf, no state change.
  - 01: {63'b0, ibuf_full}.
  - 11: {63'b0, obuf_full}.
  - 10: returns 0.
- nicEn=0: dout_nic = 0, no state change.
- CPU write (nicEn=1, nicWrEn=1):
  - 10: if obuf_full=0, obuf<=din_nic, obuf_full<=1; if full, the write is dropped silently (software polls 11 first).
  - 00/01/11: ignored.
- Receive: net_ri = ~ibuf_full. On edge with net_si & net_ri: ibuf<=net_di, ibuf_full<=1.
- Send: net_so = obuf_full & (obuf[VC_BIT] == net_polarity); net_do = obuf always. On edge with net_so & net_ro: obuf_full<=0.
- No packet field other than VC_BIT is interpreted.

## Timing
- Reset (reset=0): ibuf, obuf, both full flags = 0; hence net_ri=1, net_so=0, net_do=0, dout_nic=0 (nicEn ignored during reset).
- CPU read data valid same cycle as request (combinational from registers); status reflects flags before the edge.
- Write→net_so: earliest 1 cycle after the write edge, when polarity matches.
- Receive→status 01 reads 1: the cycle after capture edge.
- Simultaneous CPU read of 00 and net_si: net_ri=0 that cycle (full), so no capture; capture no earlier than the following edge. No bypass.
- Simultaneous CPU write of 10 and a send completing on the same edge: write is dropped (obuf_full=1 when sampled); back-to-back requires one free cycle.
- Polarity mismatch holds the packet indefinitely; net_so drops the same cycle net_polarity changes away.
- Reset asserted mid-transfer: packets in either slot are discarded; net_so deasserts asynchronously.

## Structure
- Shared header nic_defs.vh: register address codes (NIC_IBUF=2'b00, NIC_ISTAT=2'b01, NIC_OBUF=2'b10, NIC_OSTAT=2'b11), VC_BIT default.
- Sub-module nic_slot: one-entry register with full flag, load/clear inputs, async active-low reset; instantiated twice (input and output channels).
- Top adds address decode, read mux, polarity gate.

## Test plan
- Reset: hold reset=0 mid-cycle with both slots full -> all outputs 0, net_ri=1 immediately, without waiting for a clock edge.
- Output path: write 10 with 64'h0000_0000_0000_00AB (VC=0), net_polarity=1, net_ro=1 -> net_so=0; flip polarity to 0 -> net_so=1, net_do=...00AB, next edge obuf_full=0, read 11 returns 0.
- Write when full: write 10 with 64'h8000_0000_0000_0001, net_ro=0, then write 64'h8000_0000_0000_0002 -> net_do keeps ...0001; status 11 = 1.
- Input path: net_si=1, net_di=64'hDEAD_BEEF_0000_0001 -> next cycle net_ri=0, read 01 = 1, read 00 = DEAD_BEEF_0000_0001, then 01 = 0 and net_ri=1.
- Back-pressure: ibuf full, net_si=1 held with new data 64'h...0002 -> not captured until CPU reads 00; captured on the edge after the read.
- nicEn=0 with nicWrEn=1, addr 10 -> obuf unchanged, dout_nic=0.

Source files
------------

// File: rtl/cardinal_nic_pkg.sv
// Shared definitions for the Cardinal NIC: register map, widths and
// the status-word helper.
package cardinal_nic_pkg;

  localparam int NIC_DW     = 64;
  localparam int NIC_VC_BIT = 0;

  typedef enum logic [0:1] {
    NIC_IBUF  = 2'b00,
    NIC_ISTAT = 2'b01,
    NIC_OBUF  = 2'b10,
    NIC_OSTAT = 2'b11
  } nic_reg_e;

  function automatic logic [0:NIC_DW-1] stat_word(input logic flag);
    stat_word = {{(NIC_DW-1){1'b0}}, flag};
  endfunction

endpackage

// File: rtl/cardinal_nic_if.sv
// CPU NIC bus plus router-port handshake bundle.
// slave is the NIC side; master is the CPU/router side.
interface cardinal_nic_if #(
  parameter int DATA_WIDTH = 64
);

  logic [0:1]            addr_nic;
  logic [0:DATA_WIDTH-1] din_nic;
  logic [0:DATA_WIDTH-1] dout_nic;
  logic                  nicEn;
  logic                  nicWrEn;
  logic                  net_si;
  logic                  net_ri;
  logic [0:DATA_WIDTH-1] net_di;
  logic                  net_so;
  logic                  net_ro;
  logic [0:DATA_WIDTH-1] net_do;
  logic                  net_polarity;

  modport slave (
    input  addr_nic, din_nic, nicEn, nicWrEn,
    input  net_si, net_di, net_ro, net_polarity,
    output dout_nic, net_ri, net_so, net_do
  );

  modport master (
    output addr_nic, din_nic, nicEn, nicWrEn,
    output net_si, net_di, net_ro, net_polarity,
    input  dout_nic, net_ri, net_so, net_do
  );

endinterface

// File: rtl/cardinal_nic_slot.sv
// One-entry packet register with full flag.
// load wins over clear; callers never assert both.
module cardinal_nic_slot #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  clr_i,
  input  logic [0:DATA_WIDTH-1] data_i,
  output logic [0:DATA_WIDTH-1] data_o,
  output logic                  full_o
);

  logic [0:DATA_WIDTH-1] data_q, data_d;
  logic                  full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (load_i) begin
      data_d = data_i;
      full_d = 1'b1;
    end else if (clr_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/cardinal_nic.sv
// Cardinal NIC: one packet slot per direction, memory-mapped to the CPU,
// with a VC-polarity gated send handshake toward the router.
module cardinal_nic
  import cardinal_nic_pkg::*;
#(
  parameter int DATA_WIDTH = NIC_DW,
  parameter int VC_BIT     = NIC_VC_BIT
) (
  input  logic           clk,
  input  logic           reset,
  cardinal_nic_if.slave  bus
);

  logic [0:DATA_WIDTH-1] ibuf, obuf;
  logic                  ibuf_full, obuf_full;
  logic                  cpu_rd, cpu_wr;
  logic                  ibuf_ld, ibuf_clr;
  logic                  obuf_ld, obuf_clr;
  logic                  send_ok;
  logic [0:DATA_WIDTH-1] rd_data;

  assign cpu_rd = bus.nicEn & ~bus.nicWrEn;
  assign cpu_wr = bus.nicEn &  bus.nicWrEn;

  assign ibuf_ld  = bus.net_si & ~ibuf_full;
  assign ibuf_clr = cpu_rd & ibuf_full &
                    (bus.addr_nic == NIC_IBUF);

  // A write into a full slot is dropped, including on the drain edge.
  assign obuf_ld  = cpu_wr & ~obuf_full &
                    (bus.addr_nic == NIC_OBUF);
  assign send_ok  = obuf_full &
                    (obuf[VC_BIT] == bus.net_polarity);
  assign obuf_clr = send_ok & bus.net_ro;

  cardinal_nic_slot #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_islot (
    .clk    (clk),
    .rst_n  (reset),
    .load_i (ibuf_ld),
    .clr_i  (ibuf_clr),
    .data_i (bus.net_di),
    .data_o (ibuf),
    .full_o (ibuf_full)
  );

  cardinal_nic_slot #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_oslot (
    .clk    (clk),
    .rst_n  (reset),
    .load_i (obuf_ld),
    .clr_i  (obuf_clr),
    .data_i (bus.din_nic),
    .data_o (obuf),
    .full_o (obuf_full)
  );

  always_comb begin
    rd_data = '0;
    if (cpu_rd) begin
      case (bus.addr_nic)
        NIC_IBUF:  rd_data = ibuf;
        NIC_ISTAT: rd_data = stat_word(ibuf_full);
        NIC_OSTAT: rd_data = stat_word(obuf_full);
        default:   rd_data = '0;
      endcase
    end
  end

  assign bus.dout_nic = rd_data;
  assign bus.net_ri   = ~ibuf_full;
  assign bus.net_so   = send_ok;
  assign bus.net_do   = obuf;

endmodule

// File: tb/tb_cardinal_nic.sv
// Directed self-checking bench for cardinal_nic.
// Inputs change just after the rising edge; outputs are checked mid-cycle.
module tb_cardinal_nic;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;

  cardinal_nic_if bus ();

  cardinal_nic dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cpu();
    bus.nicEn   = 1'b0;
    bus.nicWrEn = 1'b0;
    bus.addr_nic = 2'b00;
    bus.din_nic = '0;
  endtask

  task automatic rd(input logic [1:0] a);
    bus.nicEn    = 1'b1;
    bus.nicWrEn  = 1'b0;
    bus.addr_nic = a;
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] d);
    bus.nicEn    = 1'b1;
    bus.nicWrEn  = 1'b1;
    bus.addr_nic = a;
    bus.din_nic  = d;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b0;
    idle_cpu();
    bus.net_si = 1'b0;
    bus.net_di = '0;
    bus.net_ro = 1'b0;
    bus.net_polarity = 1'b0;

    // Reset state, read attempted while in reset
    rd(2'b00);
    #2;
    chk("rst_ri", 64'(bus.net_ri), 64'd1);
    chk("rst_so", 64'(bus.net_so), 64'd0);
    chk("rst_do", bus.net_do, 64'd0);
    chk("rst_dout", bus.dout_nic, 64'd0);
    #10;
    reset = 1'b1;
    idle_cpu();
    tick();

    // Output path: VC=0 packet blocked by polarity 1
    wr(2'b10, 64'h0000_0000_0000_00AB);
    bus.net_polarity = 1'b1;
    bus.net_ro = 1'b1;
    tick();
    rd(2'b11);
    #1;
    chk("op_so_blk", 64'(bus.net_so), 64'd0);
    chk("op_do", bus.net_do, 64'h0000_0000_0000_00AB);
    chk("op_ostat1", bus.dout_nic, 64'd1);
    bus.net_polarity = 1'b0;
    #1;
    chk("op_so_ok", 64'(bus.net_so), 64'd1);
    tick();
    #1;
    chk("op_ostat0", bus.dout_nic, 64'd0);
    chk("op_so_off", 64'(bus.net_so), 64'd0);

    // Write while full is dropped
    bus.net_ro = 1'b0;
    wr(2'b10, 64'h8000_0000_0000_0001);
    tick();
    wr(2'b10, 64'h8000_0000_0000_0002);
    tick();
    rd(2'b11);
    #1;
    chk("wf_do", bus.net_do, 64'h8000_0000_0000_0001);
    chk("wf_ostat", bus.dout_nic, 64'd1);
    chk("wf_so_pol0", 64'(bus.net_so), 64'd0);
    bus.net_polarity = 1'b1;
    #1;
    chk("wf_so_pol1", 64'(bus.net_so), 64'd1);

    // Write coinciding with the draining edge is dropped
    bus.net_ro = 1'b1;
    wr(2'b10, 64'h8000_0000_0000_0003);
    tick();
    bus.net_ro = 1'b0;
    rd(2'b11);
    #1;
    chk("race_ostat", bus.dout_nic, 64'd0);
    chk("race_do", bus.net_do, 64'h8000_0000_0000_0001);

    // Input path
    idle_cpu();
    bus.net_si = 1'b1;
    bus.net_di = 64'hDEAD_BEEF_0000_0001;
    #1;
    chk("ip_ri_pre", 64'(bus.net_ri), 64'd1);
    tick();
    bus.net_si = 1'b0;
    rd(2'b01);
    #1;
    chk("ip_ri_full", 64'(bus.net_ri), 64'd0);
    chk("ip_istat1", bus.dout_nic, 64'd1);
    rd(2'b00);
    #1;
    chk("ip_ibuf", bus.dout_nic, 64'hDEAD_BEEF_0000_0001);
    tick();
    rd(2'b01);
    #1;
    chk("ip_istat0", bus.dout_nic, 64'd0);
    chk("ip_ri_free", 64'(bus.net_ri), 64'd1);

    // Back-pressure: second packet waits for the CPU read
    idle_cpu();
    bus.net_si = 1'b1;
    bus.net_di = 64'h0000_0000_0000_0001;
    tick();
    bus.net_di = 64'h0000_0000_0000_0002;
    tick();
    rd(2'b00);
    #1;
    chk("bp_ri_busy", 64'(bus.net_ri), 64'd0);
    chk("bp_old", bus.dout_nic, 64'h0000_0000_0000_0001);
    tick();
    rd(2'b01);
    #1;
    chk("bp_istat0", bus.dout_nic, 64'd0);
    chk("bp_ri_open", 64'(bus.net_ri), 64'd1);
    tick();
    bus.net_si = 1'b0;
    rd(2'b00);
    #1;
    chk("bp_new", bus.dout_nic, 64'h0000_0000_0000_0002);
    chk("bp_ri_full", 64'(bus.net_ri), 64'd0);

    // Disabled access: write must not load obuf
    bus.nicEn    = 1'b0;
    bus.nicWrEn  = 1'b1;
    bus.addr_nic = 2'b10;
    bus.din_nic  = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("dis_dout", bus.dout_nic, 64'd0);
    tick();
    rd(2'b11);
    #1;
    chk("dis_ostat", bus.dout_nic, 64'd0);
    chk("dis_do", bus.net_do, 64'h8000_0000_0000_0001);

    // Async reset mid-cycle with both slots full
    wr(2'b10, 64'h0000_0000_0000_00AB);
    bus.net_polarity = 1'b0;
    bus.net_ro = 1'b0;
    tick();
    rd(2'b00);
    #1;
    chk("ar_so_pre", 64'(bus.net_so), 64'd1);
    chk("ar_ri_pre", 64'(bus.net_ri), 64'd0);
    reset = 1'b0;
    #1;
    chk("ar_ri", 64'(bus.net_ri), 64'd1);
    chk("ar_so", 64'(bus.net_so), 64'd0);
    chk("ar_do", bus.net_do, 64'd0);
    chk("ar_dout", bus.dout_nic, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
